// File: rtl/counter_updown_mod_pkg.sv
// +-----------------------------------------------------------------+
// | counter_updown_mod_pkg : direction and mode constants           |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package counter_updown_mod_pkg;

  localparam logic CNT_DOWN = 1'b0;
  localparam logic CNT_UP   = 1'b1;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

endpackage

`default_nettype wire

// File: rtl/counter_updown_mod.sv
// +-----------------------------------------------------------------+
// | counter_updown_mod : modulo up/down counter, wrap or saturate    |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module counter_updown_mod
  import counter_updown_mod_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             evt,
  output logic             ovf
);

  // Compare constants carry one spare bit so MODULUS == 2**WIDTH still fits.
  localparam logic [WIDTH:0]   c_TOP   = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_TOP_Q = c_TOP[WIDTH-1:0];
  localparam logic [WIDTH:0]   c_ONE   = (WIDTH+1)'(1);

  if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_param
    $error("counter_updown_mod: illegal WIDTH/MODULUS combination");
  end

  logic [WIDTH-1:0] r_q;
  logic             r_evt;
  logic             r_ovf;

  logic [WIDTH:0]   w_q_ext;
  logic [WIDTH:0]   w_d_ext;
  logic [WIDTH:0]   w_q_inc;
  logic [WIDTH:0]   w_q_dec;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_evt_nxt;
  logic             w_ovf_nxt;
  logic             w_at_top;
  logic             w_at_zero;

  assign w_q_ext   = {1'b0, r_q};
  assign w_d_ext   = {1'b0, d};
  assign w_q_inc   = w_q_ext + c_ONE;
  assign w_q_dec   = w_q_ext - c_ONE;
  assign w_at_top  = (w_q_ext == c_TOP);
  assign w_at_zero = (r_q == '0);

  always_comb begin
    w_q_nxt   = r_q;
    w_evt_nxt = 1'b0;
    w_ovf_nxt = r_ovf;
    if (clr) begin
      w_q_nxt   = '0;
      w_ovf_nxt = 1'b0;
    end else if (load) begin
      // Out-of-range loads clamp to the top state and flag overflow.
      if (w_d_ext > c_TOP) begin
        w_q_nxt   = c_TOP_Q;
        w_ovf_nxt = 1'b1;
      end else begin
        w_q_nxt = d;
      end
    end else if (en) begin
      if (up == CNT_UP) begin
        if (w_at_top) begin
          w_evt_nxt = 1'b1;
          w_ovf_nxt = 1'b1;
          if (SATURATE == CNT_WRAP) w_q_nxt = '0;
        end else begin
          w_q_nxt = w_q_inc[WIDTH-1:0];
        end
      end else begin
        if (w_at_zero) begin
          w_evt_nxt = 1'b1;
          w_ovf_nxt = 1'b1;
          if (SATURATE == CNT_WRAP) w_q_nxt = c_TOP_Q;
        end else begin
          w_q_nxt = w_q_dec[WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_evt <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_evt <= w_evt_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign q   = r_q;
  assign evt = r_evt;
  assign ovf = r_ovf;
  assign tc  = en & ((up == CNT_UP) ? w_at_top : w_at_zero);

endmodule

`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
// +-----------------------------------------------------------------+
// | tb_counter_updown_mod : wrap and saturate instances, scoreboard  |
// | rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module tb_counter_updown_mod;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] wq, sq;
  logic         wtc, stc, wevt, sevt, wovf, sovf;

  counter_updown_mod #(.WIDTH(W), .MODULUS(M), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .d(d),
    .q(wq), .tc(wtc), .evt(wevt), .ovf(wovf));

  counter_updown_mod #(.WIDTH(W), .MODULUS(M), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load), .d(d),
    .q(sq), .tc(stc), .evt(sevt), .ovf(sovf));

  always #10 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] q0, q1;
    logic         e0, e1, o0, o1;
  } st_exp_t;

  typedef struct packed {
    logic t0, t1;
  } tc_exp_t;

  st_exp_t st_q[$];
  tc_exp_t tc_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: index 0 = wrap instance, 1 = saturate instance.
  int m_q[2];
  int m_evt[2];
  int m_ovf[2];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0; m_evt[k] = 0; m_ovf[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit e, input bit u, input bit c,
                            input bit l, input int dv);
    m_evt[k] = 0;
    if (c) begin
      m_q[k] = 0; m_ovf[k] = 0;
    end else if (l) begin
      if (dv >= M) begin m_q[k] = M - 1; m_ovf[k] = 1; end
      else m_q[k] = dv;
    end else if (e) begin
      if (u && m_q[k] == M - 1) begin
        m_evt[k] = 1; m_ovf[k] = 1;
        if (k == 0) m_q[k] = 0;
      end else if (!u && m_q[k] == 0) begin
        m_evt[k] = 1; m_ovf[k] = 1;
        if (k == 0) m_q[k] = M - 1;
      end else begin
        m_q[k] = u ? m_q[k] + 1 : m_q[k] - 1;
      end
    end
  endtask

  task automatic step(input bit e, input bit u, input bit c, input bit l, input int dv);
    tc_exp_t t;
    st_exp_t s;
    @(negedge clk);
    en = e; up = u; clr = c; load = l; d = W'(dv);
    t.t0 = e && (u ? (m_q[0] == M - 1) : (m_q[0] == 0));
    t.t1 = e && (u ? (m_q[1] == M - 1) : (m_q[1] == 0));
    tc_q.push_back(t);
    for (int k = 0; k < 2; k++) model_step(k, e, u, c, l, dv);
    s.q0 = W'(m_q[0]); s.q1 = W'(m_q[1]);
    s.e0 = m_evt[0][0]; s.e1 = m_evt[1][0];
    s.o0 = m_ovf[0][0]; s.o1 = m_ovf[1][0];
    st_q.push_back(s);
  endtask

  // Asynchronous reset between edges, checked before the next edge arrives.
  task automatic async_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_wq", 8'(wq), 8'd0);   chk("arst_sq", 8'(sq), 8'd0);
    chk("arst_wevt", 8'(wevt), 8'd0); chk("arst_wovf", 8'(wovf), 8'd0);
    chk("arst_sevt", 8'(sevt), 8'd0); chk("arst_sovf", 8'(sovf), 8'd0);
    model_reset();
    #2 rst = 1'b0;
  endtask

  initial begin : mon_state
    st_exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (st_q.size() > 0) begin
        e = st_q.pop_front();
        chk("wrap_q", 8'(wq), 8'(e.q0));
        chk("wrap_evt", 8'(wevt), 8'(e.e0));
        chk("wrap_ovf", 8'(wovf), 8'(e.o0));
        chk("sat_q", 8'(sq), 8'(e.q1));
        chk("sat_evt", 8'(sevt), 8'(e.e1));
        chk("sat_ovf", 8'(sovf), 8'(e.o1));
      end
    end
  end

  initial begin : mon_tc
    tc_exp_t t;
    forever begin
      @(negedge clk);
      #2;
      if (tc_q.size() > 0) begin
        t = tc_q.pop_front();
        chk("wrap_tc", 8'(wtc), 8'(t.t0));
        chk("sat_tc", 8'(stc), 8'(t.t1));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r;
    model_reset();
    #1;
    chk("rst_wq", 8'(wq), 8'd0);     chk("rst_sq", 8'(sq), 8'd0);
    chk("rst_wevt", 8'(wevt), 8'd0); chk("rst_wovf", 8'(wovf), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) step(1, 1, 0, 0, 0);     // wrap up through the top
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);      // wrap down through zero
    step(1, 1, 0, 1, 7);                                  // load beats enable
    step(0, 1, 0, 1, 12);                                 // out-of-range load
    step(1, 1, 1, 1, 5);                                  // clear beats load
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);      // pause at 4
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 7);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);      // pin at the top
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);
    async_reset();
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);      // down from 1 past zero

    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           r < 4, (r >= 4 && r < 14), int'($urandom_range(0, 15)));
    end

    step(0, 0, 0, 0, 0);
    @(posedge clk);
    #5;
    chk("st_queue_drained", 8'(st_q.size()), 8'd0);
    chk("tc_queue_drained", 8'(tc_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
